zoned_security_ctrl: RTL and testbench

Multi-zone successor to the single-sensor home security controller. It has:
- per-zone sensors with bypass and instant/delayed classification;
- a programmable exit delay after arming;
- an entry (pre-alarm) delay for delayed zones;
- an alarm siren timeout with automatic re-arm;
- latched trip-zone memory and a saturating alarm event counter.

It sits between the synchronised keypad/sensor inputs and the siren/indicator drivers.

---
 rtl/security_pkg.sv | 16 +
 rtl/security_delay_timer.sv | 32 +++
 rtl/zoned_security_ctrl.sv | 171 +++++++++++++++++
 tb/tb_zoned_security_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/security_pkg.sv
// Shared definitions for the zoned security controller.
// Holds the state encoding and its width. Codes 5..7 are never
// entered and are treated as DISARMED wherever they are decoded.
package security_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    DISARMED    = 3'd0,
    EXIT_DELAY  = 3'd1,
    ARMED       = 3'd2,
    ENTRY_DELAY = 3'd3,
    ALARM       = 3'd4
  } state_t;

endpackage

// File: rtl/security_delay_timer.sv
// Loadable down-counter shared by the exit delay, the entry delay and
// the siren timeout.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   load, load_value  synchronous load (takes priority over counting)
//   count             current value
//   zero              1 when count == 0
// When not loading, the counter decrements once per cycle and stops at 0.
module security_delay_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/zoned_security_ctrl.sv
// Multi-zone security controller: arms with an exit delay, gives an entry
// warning for delayed zones, drives the siren with an automatic re-arm
// timeout, records which zones tripped and counts alarm events.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   arm, disarm          keypad requests (disarm dominates)
//   zone_sensor          per-zone violation level
//   zone_instant         per-zone: 1 = straight to ALARM, 0 = via entry delay
//   zone_bypass          per-zone: 1 = ignore the zone
//   alarm                siren (ALARM only)
//   pre_alarm            entry-warning beeper (ENTRY_DELAY only)
//   armed                any state other than DISARMED
//   state                raw state code
//   trip_zones           sticky zones tripped since the last arm
//   alarm_events         saturating count of ALARM entries
//
// state       | meaning
// ------------+---------------------------------------------------
// DISARMED    | idle, sensors ignored, waits for arm
// EXIT_DELAY  | occupants leaving, sensors ignored for EXIT_DLY cycles
// ARMED       | watching active zones
// ENTRY_DELAY | delayed zone tripped, ENTRY_DLY cycles to disarm
// ALARM       | siren on; re-arms after ALARM_TIMEOUT (0 = never)
module zoned_security_ctrl
  import security_pkg::*;
#(
  parameter int NUM_ZONES     = 4,
  parameter int CNT_W         = 16,
  parameter int EXIT_DLY      = 16,
  parameter int ENTRY_DLY     = 16,
  parameter int ALARM_TIMEOUT = 64,
  parameter int EVT_W         = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic [NUM_ZONES-1:0] zone_sensor,
  input  logic [NUM_ZONES-1:0] zone_instant,
  input  logic [NUM_ZONES-1:0] zone_bypass,
  output logic                 alarm,
  output logic                 pre_alarm,
  output logic                 armed,
  output logic [STATE_W-1:0]   state,
  output logic [NUM_ZONES-1:0] trip_zones,
  output logic [EVT_W-1:0]     alarm_events
);

  // Load values are "dwell - 1": the state is left on the edge after the
  // counter has reached zero, giving exactly the programmed dwell.
  localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_DLY - 1);
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DLY - 1);
  localparam logic [CNT_W-1:0] ALM_LD   =
    (ALARM_TIMEOUT > 0) ? CNT_W'(ALARM_TIMEOUT - 1) : '0;
  localparam bit ALM_AUTO_REARM = (ALARM_TIMEOUT > 0);

  state_t st_q, st_d;

  logic                 tmr_load;
  logic [CNT_W-1:0]     tmr_val;
  logic [CNT_W-1:0]     tmr_count;
  logic                 tmr_zero;
  logic                 trip_clr;
  logic                 trip_acc;
  logic                 alarm_entry;
  logic [NUM_ZONES-1:0] active;
  logic                 inst_hit;
  logic                 any_hit;

  assign active   = zone_sensor & ~zone_bypass;
  assign inst_hit = |(active & zone_instant);
  assign any_hit  = |active;

  security_delay_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (tmr_load),
    .load_value (tmr_val),
    .count      (tmr_count),
    .zero       (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= DISARMED;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    trip_clr = 1'b0;
    trip_acc = 1'b0;
    if (disarm) begin
      st_d     = DISARMED;
      tmr_load = 1'b1;
    end else begin
      case (st_q)
        EXIT_DELAY: begin
          if (tmr_zero) st_d = ARMED;
        end
        ARMED: begin
          trip_acc = 1'b1;
          if (inst_hit) begin
            st_d     = ALARM;
            tmr_load = 1'b1;
            tmr_val  = ALM_LD;
          end else if (any_hit) begin
            st_d     = ENTRY_DELAY;
            tmr_load = 1'b1;
            tmr_val  = ENTRY_LD;
          end
        end
        ENTRY_DELAY: begin
          trip_acc = 1'b1;
          if (inst_hit || tmr_zero) begin
            st_d     = ALARM;
            tmr_load = 1'b1;
            tmr_val  = ALM_LD;
          end
        end
        ALARM: begin
          trip_acc = 1'b1;
          if (ALM_AUTO_REARM && tmr_zero) st_d = ARMED;
        end
        default: begin
          // DISARMED and the unreachable codes behave identically.
          if (arm) begin
            st_d     = EXIT_DELAY;
            tmr_load = 1'b1;
            tmr_val  = EXIT_LD;
            trip_clr = 1'b1;
          end
        end
      endcase
    end
  end

  assign alarm_entry = (st_d == ALARM) && (st_q != ALARM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trip_zones   <= '0;
      alarm_events <= '0;
    end else begin
      if (trip_clr) begin
        trip_zones <= '0;
      end else if (trip_acc) begin
        trip_zones <= trip_zones | active;
      end
      if (alarm_entry && (alarm_events != '1)) begin
        alarm_events <= alarm_events + EVT_W'(1);
      end
    end
  end

  always_comb begin
    alarm     = (st_q == ALARM);
    pre_alarm = (st_q == ENTRY_DELAY);
    armed     = (st_q == EXIT_DELAY) || (st_q == ARMED) ||
                (st_q == ENTRY_DELAY) || (st_q == ALARM);
  end

  assign state = st_q;

endmodule

// File: tb/tb_zoned_security_ctrl.sv
// Self-checking bench for zoned_security_ctrl: directed scenarios followed
// by randomized traffic, all compared against a cycle-level reference model
// that tracks time-in-state rather than a down-counter.
module tb_zoned_security_ctrl;

  localparam int NZ = 4;
  localparam int CW = 16;
  localparam int XD = 4;
  localparam int ND = 6;
  localparam int TO = 10;
  localparam int EW = 8;

  localparam int S_DIS = 0;
  localparam int S_EXIT = 1;
  localparam int S_ARM = 2;
  localparam int S_ENT = 3;
  localparam int S_ALM = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          arm = 1'b0;
  logic          disarm = 1'b0;
  logic [NZ-1:0] zs = '0;
  logic [NZ-1:0] zi = '0;
  logic [NZ-1:0] zb = '0;

  logic          alarm;
  logic          pre_alarm;
  logic          armed;
  logic [2:0]    state;
  logic [NZ-1:0] trip_zones;
  logic [EW-1:0] alarm_events;

  int n_chk = 0;
  int n_pass = 0;

  int            m_st;
  int            m_age;
  logic [NZ-1:0] m_trip;
  int            m_evt;

  zoned_security_ctrl #(
    .NUM_ZONES     (NZ),
    .CNT_W         (CW),
    .EXIT_DLY      (XD),
    .ENTRY_DLY     (ND),
    .ALARM_TIMEOUT (TO),
    .EVT_W         (EW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .arm          (arm),
    .disarm       (disarm),
    .zone_sensor  (zs),
    .zone_instant (zi),
    .zone_bypass  (zb),
    .alarm        (alarm),
    .pre_alarm    (pre_alarm),
    .armed        (armed),
    .state        (state),
    .trip_zones   (trip_zones),
    .alarm_events (alarm_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic void model_reset();
    m_st   = S_DIS;
    m_age  = 0;
    m_trip = '0;
    m_evt  = 0;
  endfunction

  // One clock edge of the reference behaviour, using the inputs that are
  // stable at that edge. m_age = edges already spent in the current state.
  function automatic void model_edge();
    logic [NZ-1:0] act;
    bit ih, ah;
    int nxt;
    if (!reset_n) begin
      model_reset();
      return;
    end
    act = zs & ~zb;
    ih  = |(act & zi);
    ah  = |act;
    nxt = m_st;
    if (disarm) begin
      nxt = S_DIS;
    end else begin
      case (m_st)
        S_DIS: if (arm) begin nxt = S_EXIT; m_trip = '0; end
        S_EXIT: if (m_age + 1 >= XD) nxt = S_ARM;
        S_ARM: begin
          m_trip |= act;
          if (ih) nxt = S_ALM;
          else if (ah) nxt = S_ENT;
        end
        S_ENT: begin
          m_trip |= act;
          if (ih || m_age + 1 >= ND) nxt = S_ALM;
        end
        S_ALM: begin
          m_trip |= act;
          if (TO > 0 && m_age + 1 >= TO) nxt = S_ARM;
        end
        default: nxt = S_DIS;
      endcase
    end
    if (nxt == S_ALM && m_st != S_ALM && m_evt < 255) m_evt++;
    if (nxt != m_st) m_age = 0;
    else m_age++;
    m_st = nxt;
  endfunction

  task automatic compare_all();
    chk("state", 32'(state), 32'(m_st));
    chk("alarm", 32'(alarm), 32'(m_st == S_ALM));
    chk("pre_alarm", 32'(pre_alarm), 32'(m_st == S_ENT));
    chk("armed", 32'(armed), 32'(m_st != S_DIS));
    chk("trip_zones", 32'(trip_zones), 32'(m_trip));
    chk("alarm_events", 32'(alarm_events), 32'(m_evt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    compare_all();
    step();
    step();
    reset_n = 1'b1;

    // 1: arm with zone 0 violated during exit; sensors ignored
    zs = 4'b0001; arm = 1'b1;
    step();
    arm = 1'b0;
    chk("t1_armed_now", 32'(armed), 32'd1);
    chk("t1_exit", 32'(state), 32'(S_EXIT));
    repeat (3) step();
    chk("t1_still_exit", 32'(state), 32'(S_EXIT));
    step();
    zs = '0;
    chk("t1_armed_state", 32'(state), 32'(S_ARM));
    chk("t1_trip", 32'(trip_zones), 32'd0);
    chk("t1_alarm", 32'(alarm), 32'd0);

    // 2: delayed zone pulse -> 6 cycles pre_alarm -> alarm
    zi = '0; zs = 4'b0001;
    step();
    zs = '0;
    chk("t2_entry", 32'(state), 32'(S_ENT));
    for (int i = 1; i < ND; i++) begin
      step();
      chk("t2_pre", 32'(pre_alarm), 32'd1);
    end
    step();
    chk("t2_alarm", 32'(alarm), 32'd1);
    chk("t2_trip", 32'(trip_zones), 32'b0001);
    chk("t2_evt", 32'(alarm_events), 32'd1);
    disarm = 1'b1;
    step();
    disarm = 1'b0;
    chk("t2_disarmed", 32'(state), 32'(S_DIS));
    chk("t2_trip_kept", 32'(trip_zones), 32'b0001);

    // 3: disarm on the third entry-delay cycle
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (XD) step();
    zs = 4'b0001;
    step();
    zs = '0;
    step();
    step();
    disarm = 1'b1;
    step();
    disarm = 1'b0;
    chk("t3_disarmed", 32'(state), 32'(S_DIS));
    repeat (8) begin
      step();
      chk("t3_no_alarm", 32'(alarm), 32'd0);
    end
    chk("t3_evt", 32'(alarm_events), 32'd1);

    // 4: instant zone 2 -> alarm next edge, 10-cycle siren, re-arm
    zi = 4'b0100;
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (XD) step();
    zs = 4'b0100;
    step();
    zs = '0;
    chk("t4_alarm", 32'(alarm), 32'd1);
    for (int i = 1; i < TO; i++) begin
      step();
      chk("t4_alarm_hold", 32'(alarm), 32'd1);
    end
    step();
    chk("t4_rearmed", 32'(state), 32'(S_ARM));
    chk("t4_trip", 32'(trip_zones), 32'b0100);
    chk("t4_evt", 32'(alarm_events), 32'd2);

    // 5: bypassed zone ignored; arm+disarm together -> disarm wins
    zb = 4'b0010; zs = 4'b0010;
    repeat (5) begin
      step();
      chk("t5_bypass", 32'(state), 32'(S_ARM));
    end
    zs = '0; arm = 1'b1; disarm = 1'b1;
    step();
    arm = 1'b0; disarm = 1'b0; zb = '0;
    chk("t5_disarm_wins", 32'(state), 32'(S_DIS));

    // 6: async reset mid-alarm, then saturation of the event counter
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (XD) step();
    zs = 4'b0100;
    step();
    chk("t6_alarm", 32'(alarm), 32'd1);
    step();
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_alarm", 32'(alarm), 32'd0);
    chk("t6_rst_armed", 32'(armed), 32'd0);
    chk("t6_rst_pre", 32'(pre_alarm), 32'd0);
    chk("t6_rst_state", 32'(state), 32'd0);
    chk("t6_rst_trip", 32'(trip_zones), 32'd0);
    chk("t6_rst_evt", 32'(alarm_events), 32'd0);
    model_reset();
    step();
    reset_n = 1'b1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 0; i < 4000 && m_evt < 255; i++) step();
    repeat (30) step();
    chk("t6_saturated", 32'(alarm_events), 32'd255);
    zs = '0;

    // randomized traffic
    disarm = 1'b1;
    step();
    disarm = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      arm    = ($urandom % 8) == 0;
      disarm = ($urandom % 40) == 0;
      for (int z = 0; z < NZ; z++) zs[z] = ($urandom % 12) == 0;
      if ((i % 64) == 0) begin
        zi = NZ'($urandom);
        zb = NZ'($urandom);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
